// File: rtl/prefetch_queue.sv
// Instruction-byte prefetcher: fetches sequential bytes (optionally two at a time)
// into a small byte queue and hands them to the decoder through a valid/ready pop port.
module prefetch_queue #(
  parameter int unsigned          ADDR_W     = 16,
  parameter int unsigned          DEPTH      = 4,
  parameter int unsigned          DBL_FETCH  = 1,
  parameter logic [ADDR_W-1:0]    RESET_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          flush,
  input  logic [ADDR_W-1:0]             flush_addr,
  input  logic                          fetch_en,
  output logic                          mem_read_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          dbl_byte_en,
  input  logic [15:0]                   mem_data_in,
  input  logic                          mem_ack,
  output logic                          out_valid,
  output logic [7:0]                    out_byte,
  output logic [ADDR_W-1:0]             out_addr,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fetch_addr, fetch_addr_next;
  logic [ADDR_W-1:0] head_addr;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [7:0]        mem [DEPTH];

  logic       issue;
  logic       dbl_issue;
  logic       push_one;
  logic       push_two;
  logic [1:0] push_n;
  logic       pop;

  assign mem_read_en = (state != IDLE);
  assign out_valid   = (count_q != '0);
  assign out_byte    = mem[rd_ptr];
  assign out_addr    = head_addr;
  assign count       = count_q;

  // Space is checked against the registered count, so any bytes granted here are
  // guaranteed to fit when the ack arrives (pops during FETCH only free more room).
  assign dbl_issue = (DBL_FETCH != 0) && (count_q <= CW'(DEPTH - 2)) && !fetch_addr[0];

  always_comb begin
    state_next      = state;
    fetch_addr_next = fetch_addr;
    issue           = 1'b0;
    push_one        = 1'b0;
    push_two        = 1'b0;
    pop             = out_ready && (count_q != '0) && !flush;
    unique case (state)
      IDLE: begin
        if (flush) begin
          fetch_addr_next = flush_addr;
        end else if (fetch_en && (count_q < CW'(DEPTH))) begin
          issue      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (flush) begin
          fetch_addr_next = flush_addr;
          state_next      = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          push_one        = 1'b1;
          push_two        = dbl_byte_en;
          fetch_addr_next = fetch_addr + (dbl_byte_en ? ADDR_W'(2) : ADDR_W'(1));
          state_next      = IDLE;
        end
      end
      DRAIN: begin
        if (flush) begin
          fetch_addr_next = flush_addr;
        end
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    push_n = push_two ? 2'd2 : (push_one ? 2'd1 : 2'd0);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state       <= IDLE;
      fetch_addr  <= RESET_ADDR;
      mem_addr    <= RESET_ADDR;
      dbl_byte_en <= 1'b0;
      head_addr   <= RESET_ADDR;
      count_q     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state      <= state_next;
      fetch_addr <= fetch_addr_next;
      if (issue) begin
        mem_addr    <= fetch_addr;
        dbl_byte_en <= dbl_issue;
      end
      if (flush) begin
        head_addr <= flush_addr;
        count_q   <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
      end else begin
        if (push_one) begin
          mem[wr_ptr] <= mem_data_in[7:0];
        end
        if (push_two) begin
          mem[wr_ptr + PW'(1)] <= mem_data_in[15:8];
        end
        wr_ptr    <= wr_ptr + PW'(push_n);
        rd_ptr    <= rd_ptr + PW'(pop);
        head_addr <= head_addr + ADDR_W'(pop);
        count_q   <= count_q + CW'(push_n) - CW'(pop);
      end
    end
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Parametrised instruction-byte prefetcher that sits between the memory controller and the instruction register/decoder in the z23 control unit. It fetches sequential instruction bytes ahead of execution into a DEPTH-entry byte queue, optionally using double-byte fetches. It supplies bytes to the decoder through a valid/ready pop interface, and flushes and redirects on jumps, calls and interrupts. Fetches that are already in flight are always completed and discarded, never aborted.

## Interface
Parameters:
- ADDR_W, 16, width of fetch and byte addresses.
- DEPTH, 4, queue depth in bytes; a power of two, ≥2.
- DBL_FETCH, 1, 1 enables double-byte fetches; 0 restricts fetches to single bytes.
- RESET_ADDR, 16'h0000, fetch address after reset.

Ports:
- clk  in  1  the single clock.
- nrst  in  1  reset: synchronous, active-high.
- flush  in  1  discard the queue and redirect fetch to flush_addr.
- flush_addr  in  ADDR_W  new fetch/head address; sampled when flush=1.
- fetch_en  in  1  permission to start a new fetch (low while the decoder owns the memory port).
- mem_read_en  out  1  fetch request to the memory controller.
- mem_addr  out  ADDR_W  fetch address.
- dbl_byte_en  out  1  double-byte request.
- mem_data_in  in  16  read data; byte at addr in [7:0], byte at addr+1 in [15:8].
- mem_ack  in  1  one-cycle completion strobe.
- out_valid  out  1  queue non-empty.
- out_byte  out  8  head byte.
- out_addr  out  ADDR_W  address of the head byte.
- out_ready  in  1  pop the head byte when out_valid=1.
- count  out  $clog2(DEPTH+1)  bytes currently queued.

## Operation
- FSM states are IDLE, FETCH and DRAIN.
- **IDLE.** A request is issued, with the next state FETCH, only when all of these hold:
  - fetch_en=1;
  - flush=0;
  - free = DEPTH−count ≥ 1, using the registered count.
- **Request latch.** On issue, mem_addr ← fetch_addr and dbl_byte_en ← (DBL_FETCH && free≥2 && fetch_addr[0]==0).
- **FETCH.** mem_read_en=1. mem_addr and dbl_byte_en stay stable until mem_ack.
  - On mem_ack, push [7:0] then [15:8] (the second byte only when dbl).
  - fetch_addr advances by 1 or 2, modulo 2^ADDR_W.
  - The next state is IDLE.
- **Back-pressure.** fetch_en is ignored while in FETCH: a started request is never withdrawn. Queue space is reserved at issue time, so a push never overflows.
- **Flush in IDLE.**
  - Queue emptied (count=0).
  - fetch_addr ← flush_addr and head address ← flush_addr.
  - Any pop in the same cycle is ignored.
- **Flush in FETCH or DRAIN.**
  - Queue emptied; fetch_addr and head address ← flush_addr.
  - The next state is DRAIN.
  - DRAIN keeps mem_read_en=1 with the old address until mem_ack, then discards the data (no push) and returns to IDLE without advancing fetch_addr.
  - Flush with mem_ack in the same cycle: the data is discarded, fetch_addr ← flush_addr, and the next state is IDLE.
- **Pop.** out_ready && out_valid && !flush removes the head byte; out_addr increments by 1, wrapping.
  - A pop while empty is ignored.
  - Pop and push in the same cycle are allowed; count changes by push_n−1.
- **Priority.** nrst > flush > push/pop.
- Queue read/write pointers are log2(DEPTH) bits and wrap naturally.
- **Reset values.**
  - state IDLE; count 0.
  - out_valid 0; out_byte 0.
  - out_addr RESET_ADDR; fetch_addr RESET_ADDR; mem_addr RESET_ADDR.
  - mem_read_en 0; dbl_byte_en 0.

## Timing
- All outputs are registered or decoded from registers; there is no combinational path from mem_ack, flush or out_ready to any output.
- mem_read_en rises one cycle after the IDLE issue condition holds. With fetch_en=1 held, it is high in the first cycle after reset deasserts.
- A pushed byte is visible on out_valid/out_byte the cycle after mem_ack.
- Minimum fetch cadence is 2 cycles when mem_ack returns in the first FETCH cycle; IDLE lasts at least 1 cycle between requests.
- A flush takes effect at the clock edge where it is sampled: out_valid=0 and out_addr=flush_addr in the next cycle.
- The first post-flush request issues 1 cycle after that edge from IDLE, or 1 cycle after the draining mem_ack.
- Reset asserted mid-FETCH drops the request (mem_read_en=0) in the next cycle; the memory controller is reset alongside.

## Test plan
- **Reset fetch:** RESET_ADDR=0x0100, DBL_FETCH=1, fetch_en=1, ack after 1 cycle with data 0xBBAA.
  - mem_read_en=1, addr=0x0100, dbl=1.
  - Then out_byte=0xAA with out_addr=0x0100, then 0xBB with out_addr=0x0101; next fetch at 0x0102.
- **Odd address / low space:** flush to 0x0201; ack data 0x0077.
  - Single-byte fetch, 0x77 queued.
  - Next fetch at 0x0202 is double only if free≥2; with DEPTH=4 and 3 queued it is single.
- **Full queue:** out_ready=0 until count=DEPTH.
  - mem_read_en stays 0.
  - One pop re-enables a fetch; count never exceeds DEPTH.
- **Flush during FETCH:** flush to 0x0400 while the request at 0x0102 is pending.
  - mem_read_en held with addr 0x0102 until ack; data not pushed.
  - Next request at 0x0400; out_addr=0x0400.
- **Simultaneous events:** pop+push in one cycle keeps count constant; flush+pop+ack in one cycle leaves count=0 and state IDLE.
- **Wrap:** fetch_addr=0xFFFF, DBL_FETCH=0, two single fetches.
  - Addresses 0xFFFF then 0x0000.
  - out_addr wraps identically.
